// File: rtl/fft_bitrev_stream.sv
// Streaming bit-reversal reorder buffer: natural-order complex samples in, each
// N-sample frame out in bit-reversed order, ping-ponging between two banks.
module fft_bitrev_stream #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [$clog2(N)-1:0]    m_index
);
  localparam int AW = $clog2(N);
  localparam int SW = 2*DATA_WIDTH;
  localparam logic [AW-1:0] CNT_LAST = AW'(N-1);

  logic [1:0][N-1:0][SW-1:0] bank_q, bank_d;
  logic [1:0]                full_q, full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [AW-1:0]             wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]             rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]             rd_addr;
  logic                      wr_fire, rd_fire;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Handshake flags depend on state only, so no input-to-output combinational path.
  assign s_ready = !full_q[wr_bank_q];
  assign m_valid = full_q[rd_bank_q];
  assign rd_addr = bitrev(rd_cnt_q);
  assign m_data  = bank_q[rd_bank_q][rd_addr];
  assign m_index = rd_cnt_q;
  assign m_last  = m_valid && (rd_cnt_q == CNT_LAST);

  assign wr_fire = s_valid && s_ready;
  assign rd_fire = m_valid && m_ready;

  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    // The write bank is never full when written, so set and clear below
    // always land on different full bits.
    if (wr_fire) begin
      bank_d[wr_bank_q][wr_cnt_q] = s_data;
      if (wr_cnt_q == CNT_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == CNT_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_cnt_d          = '0;
        rd_bank_d         = !rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q    <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_stream.sv
// Directed bench for fft_bitrev_stream: N=16 ordering, streaming, backpressure,
// random stalls, mid-frame reset, plus an N=4 instance.
module tb_fft_bitrev_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data, m_data;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [3:0]  m_index;

  logic [31:0] s4_data, m4_data;
  logic        s4_valid, s4_ready, m4_valid, m4_ready, m4_last;
  logic [1:0]  m4_index;

  int checks = 0;
  int failures = 0;

  int br16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [31:0] outq[$];

  fft_bitrev_stream #(.N(16), .DATA_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_index(m_index)
  );

  fft_bitrev_stream #(.N(4), .DATA_WIDTH(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s4_data), .s_valid(s4_valid), .s_ready(s4_ready),
    .m_data(m4_data), .m_valid(m4_valid), .m_ready(m4_ready),
    .m_last(m4_last), .m_index(m4_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] samp(input int v);
    return {16'(v) + 16'h1000, ~16'(v)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_lo, gaps, nxt, acc, nin, nout;
    s_valid = 0; s_data = '0; m_ready = 0;
    s4_valid = 0; s4_data = '0; m4_ready = 0;
    step();
    rst_n = 1'b1;

    // reset state
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_index", m_index, 0);
    chk("rst4_m_valid", m4_valid, 0);

    // natural 0..15 in, bit-reversed out
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      if (i == 15) chk("ord_no_early_valid", m_valid, 0);
      step();
    end
    s_valid = 1'b0;
    chk("ord_latency", m_valid, 1);
    for (int k = 0; k < 16; k++) begin
      m_ready = 1'b1;
      chk("ord_data", m_data, br16[k]);
      chk("ord_index", m_index, k);
      chk("ord_last", m_last, (k == 15));
      step();
    end
    m_ready = 1'b0;
    chk("ord_empty", m_valid, 0);

    // three back-to-back frames
    do_reset();
    n_lo = 0; gaps = 0;
    outq.delete();
    for (int c = 0; c < 66; c++) begin
      s_valid = (c < 48); s_data = 32'(c); m_ready = 1'b1;
      if (s_valid && !s_ready) n_lo++;
      if (m_valid) outq.push_back(m_data);
      else if (c >= 16 && c < 64) gaps++;
      step();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("stream_sready_low", n_lo, 0);
    chk("stream_gaps", gaps, 0);
    chk("stream_count", outq.size(), 48);
    for (int j = 0; j < outq.size(); j++)
      chk("stream_data", outq[j], (j / 16) * 16 + br16[j % 16]);

    // backpressure: both banks fill, then drain one
    do_reset();
    nxt = 0; acc = 0;
    for (int c = 0; c < 40; c++) begin
      s_valid = (nxt < 40); s_data = 32'(nxt);
      if (s_valid && s_ready) begin acc++; nxt++; end
      step();
    end
    chk("bp_accepted", acc, 32);
    chk("bp_sready", s_ready, 0);
    chk("bp_mvalid", m_valid, 1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_data", m_data, 0);
      chk("bp_hold_index", m_index, 0);
      step();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("bp_data", m_data, br16[k]);
      if (k == 15) chk("bp_sready_last", s_ready, 0);
      step();
    end
    chk("bp_sready_back", s_ready, 1);
    chk("bp_next_frame", m_data, 16);
    s_valid = 1'b0; m_ready = 1'b0;

    // random stalls on both sides over 10 frames
    do_reset();
    nin = 0; nout = 0;
    for (int c = 0; c < 3000 && nout < 160; c++) begin
      s_valid = (nin < 160) && ($urandom_range(0, 3) != 0);
      s_data  = samp(nin);
      m_ready = ($urandom_range(0, 2) != 0);
      if (s_valid && s_ready) nin++;
      if (m_valid && m_ready) begin
        chk("rnd_data", m_data, samp((nout / 16) * 16 + br16[nout % 16]));
        chk("rnd_index", m_index, nout % 16);
        nout++;
      end
      step();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("rnd_out_count", nout, 160);
    chk("rnd_in_count", nin, 160);
    chk("rnd_empty", m_valid, 0);

    // reset while frame 1 half drained and frame 2 partially written
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = samp(i);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = samp(100 + i); m_ready = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
    chk("mr_pre_valid", m_valid, 1);
    chk("mr_pre_index", m_index, 8);
    rst_n = 1'b0; m_ready = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_m_valid", m_valid, 0);
    chk("mr_s_ready", s_ready, 1);
    chk("mr_m_data", m_data, 0);
    chk("mr_m_index", m_index, 0);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = samp(200 + i);
      step();
    end
    s_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_ready = 1'b1;
      chk("mr_data", m_data, samp(200 + br16[k]));
      chk("mr_last", m_last, (k == 15));
      step();
    end
    m_ready = 1'b0;
    chk("mr_empty", m_valid, 0);

    // N=4 instance: A,B,C,D -> A,C,B,D
    begin
      logic [31:0] v4[4];
      logic [31:0] e4[4];
      v4[0] = 32'hAAAA_0001; v4[1] = 32'hBBBB_0002;
      v4[2] = 32'hCCCC_0003; v4[3] = 32'hDDDD_0004;
      e4[0] = 32'hAAAA_0001; e4[1] = 32'hCCCC_0003;
      e4[2] = 32'hBBBB_0002; e4[3] = 32'hDDDD_0004;
      for (int i = 0; i < 4; i++) begin
        s4_valid = 1'b1; s4_data = v4[i];
        step();
      end
      s4_valid = 1'b0;
      chk("n4_latency", m4_valid, 1);
      for (int k = 0; k < 4; k++) begin
        m4_ready = 1'b1;
        chk("n4_data", m4_data, e4[k]);
        chk("n4_index", m4_index, k);
        chk("n4_last", m4_last, (k == 3));
        step();
      end
      m4_ready = 1'b0;
      chk("n4_empty", m4_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
